// File: rtl/multi_strobe_gen_pkg.sv
// Shared constants and types for the multi-channel strobe generator.
package multi_strobe_gen_pkg;

    localparam int unsigned BOARD_CLK_MHZ = 100;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } strobe_state_t;

    typedef enum logic {
        PERIODIC,
        ONESHOT
    } strobe_mode_t;

    // Clock cycles per strobe at the given rate; callers truncate to their counter width.
    function automatic logic [63:0] reset_period(input logic [63:0] freq_hz);
        return (64'(BOARD_CLK_MHZ) * 64'd1_000_000) / freq_hz;
    endfunction

    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/multi_strobe_gen_if.sv
// Configuration write port: one channel's period and mode per valid/ready transfer.
interface multi_strobe_gen_if
    import multi_strobe_gen_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32
);
    localparam int CH_W = ch_width(N_CH);

    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [CH_W-1:0]  cfg_ch_i;
    logic [CNT_W-1:0] cfg_period_i;
    logic             cfg_oneshot_i;
    logic             cfg_err_o;

    modport master (
        output cfg_valid_i, cfg_ch_i, cfg_period_i, cfg_oneshot_i,
        input  cfg_ready_o, cfg_err_o
    );

    modport slave (
        input  cfg_valid_i, cfg_ch_i, cfg_period_i, cfg_oneshot_i,
        output cfg_ready_o, cfg_err_o
    );

endinterface

// File: rtl/multi_strobe_gen_strobe_channel.sv
// One strobe channel: IDLE/RUN/DONE FSM with its own counter, period and mode.
module strobe_channel
    import multi_strobe_gen_pkg::*;
#(
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] RST_PERIOD = CNT_W'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_period,
    input  strobe_mode_t     wr_mode,
    output logic             strobe,
    output logic             busy
);

    strobe_state_t    state, state_nx;
    strobe_mode_t     mode, mode_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] period, period_nx;
    logic             strobe_nx;

    // NOTE: the period and mode registers are reset too, so a channel enabled
    // straight out of reset runs at the default rate instead of an unknown one.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mode   <= PERIODIC;
            cnt    <= '0;
            period <= RST_PERIOD;
            strobe <= 1'b0;
        end else begin
            state  <= state_nx;
            mode   <= mode_nx;
            cnt    <= cnt_nx;
            period <= period_nx;
            strobe <= strobe_nx;
        end
    end

    // NOTE: every variable gets a default before any branch, otherwise a path
    // that skips an assignment would infer a latch.
    always_comb begin
        state_nx  = state;
        mode_nx   = mode;
        cnt_nx    = cnt;
        period_nx = period;
        strobe_nx = 1'b0;

        if (wr) begin
            // A zero period would never match cnt, so it is stored as one.
            period_nx = (wr_period == '0) ? CNT_W'(1) : wr_period;
            mode_nx   = wr_mode;
            cnt_nx    = '0;
            state_nx  = en ? RUN : IDLE;
        end else if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
                RUN: begin
                    if (cnt == period - CNT_W'(1)) begin
                        strobe_nx = 1'b1;
                        cnt_nx    = '0;
                        if (mode == ONESHOT) state_nx = DONE;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                DONE:    state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == RUN);
    end

endmodule

// File: rtl/multi_strobe_gen.sv
// N_CH independent programmable strobe channels behind one configuration write port.
module multi_strobe_gen
    import multi_strobe_gen_pkg::*;
#(
    parameter int          N_CH            = 4,
    parameter int          CNT_W           = 32,
    parameter int unsigned DEFAULT_FREQ_HZ = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    multi_strobe_gen_if.slave     cfg,
    input  logic [N_CH-1:0]       en_i,
    output logic [N_CH-1:0]       strobe_o,
    output logic [N_CH-1:0]       busy_o
);

    localparam int               CH_W       = ch_width(N_CH);
    localparam logic [63:0]      RST_P64    = reset_period(64'(DEFAULT_FREQ_HZ));
    localparam logic [CNT_W-1:0] RST_PERIOD = RST_P64[CNT_W-1:0];

    logic            accept;
    logic            in_range;
    logic            ready_pre;
    logic [N_CH-1:0] wr;
    strobe_mode_t    wr_mode;

    assign accept   = cfg.cfg_valid_i && cfg.cfg_ready_o;
    assign in_range = int'(cfg.cfg_ch_i) < N_CH;
    assign wr_mode  = strobe_mode_t'(cfg.cfg_oneshot_i);

    // Ready rises on the second edge after reset release, giving one settling cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_pre       <= 1'b0;
            cfg.cfg_ready_o <= 1'b0;
            cfg.cfg_err_o   <= 1'b0;
        end else begin
            ready_pre       <= 1'b1;
            cfg.cfg_ready_o <= ready_pre;
            cfg.cfg_err_o   <= accept && !in_range;
        end
    end

    always_comb begin
        wr = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (accept && cfg.cfg_ch_i == CH_W'(i)) wr[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        strobe_channel #(
            .CNT_W      (CNT_W),
            .RST_PERIOD (RST_PERIOD)
        ) u_ch (
            .clk       (clk_i),
            .rst       (rst_i),
            .en        (en_i[g]),
            .wr        (wr[g]),
            .wr_period (cfg.cfg_period_i),
            .wr_mode   (wr_mode),
            .strobe    (strobe_o[g]),
            .busy      (busy_o[g])
        );
    end

endmodule

// File: tb/tb_multi_strobe_gen.sv
// Directed bench for multi_strobe_gen with three channels and a 10-cycle default period.
module tb_multi_strobe_gen;
    import multi_strobe_gen_pkg::*;

    localparam int N_CH  = 3;
    localparam int CNT_W = 32;

    logic            clk;
    logic            rst;
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] strobe;
    logic [N_CH-1:0] busy;

    int tests = 0;
    int fails = 0;

    multi_strobe_gen_if #(.N_CH(N_CH), .CNT_W(CNT_W)) cfg_bus ();

    multi_strobe_gen #(
        .N_CH            (N_CH),
        .CNT_W           (CNT_W),
        .DEFAULT_FREQ_HZ (BOARD_CLK_MHZ * 100_000)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .cfg      (cfg_bus.slave),
        .en_i     (en),
        .strobe_o (strobe),
        .busy_o   (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic [2:0] es, input logic [2:0] eb);
        check(tag, {2'b00, busy, strobe}, {2'b00, eb, es});
    endtask

    task automatic tick_check(input string tag, input logic [2:0] es, input logic [2:0] eb);
        step();
        check_status(tag, es, eb);
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [31:0] p, input logic oneshot);
        cfg_bus.cfg_valid_i   = 1'b1;
        cfg_bus.cfg_ch_i      = ch;
        cfg_bus.cfg_period_i  = p;
        cfg_bus.cfg_oneshot_i = oneshot;
        step();
        cfg_bus.cfg_valid_i   = 1'b0;
    endtask

    initial begin
        rst                   = 1'b1;
        en                    = '0;
        cfg_bus.cfg_valid_i   = 1'b0;
        cfg_bus.cfg_ch_i      = '0;
        cfg_bus.cfg_period_i  = '0;
        cfg_bus.cfg_oneshot_i = 1'b0;

        // Reset values and ready timing
        #2;
        check_status("rst_status", 3'b000, 3'b000);
        check("rst_ready", {7'b0, cfg_bus.cfg_ready_o}, 8'd0);
        check("rst_err", {7'b0, cfg_bus.cfg_err_o}, 8'd0);
        step();
        rst = 1'b0;
        step();
        check("ready_edge1", {7'b0, cfg_bus.cfg_ready_o}, 8'd0);
        step();
        check("ready_edge2", {7'b0, cfg_bus.cfg_ready_o}, 8'd1);
        check_status("idle_after_rst", 3'b000, 3'b000);

        // Default period of 10 on channel 0
        en = 3'b001;
        step();
        check_status("p1_arm", 3'b000, 3'b001);
        for (int k = 1; k <= 25; k++)
            tick_check("p1_cadence", (k % 10 == 0) ? 3'b001 : 3'b000, 3'b001);

        // Runtime write ch1 P=3; ch0 keeps its cadence (ch0 edge 26 is the write edge)
        en = 3'b011;
        cfg_write(2'd1, 32'd3, 1'b0);
        check_status("p2_wr_edge", 3'b000, 3'b011);
        check("p2_no_err", {7'b0, cfg_bus.cfg_err_o}, 8'd0);
        for (int j = 1; j <= 12; j++)
            tick_check("p2_cadence", {1'b0, (j % 3 == 0), ((26 + j) % 10 == 0)}, 3'b011);

        // One-shot P=5 on ch0, then re-arm
        en = 3'b001;
        cfg_write(2'd0, 32'd5, 1'b1);
        check_status("p3_wr_edge", 3'b000, 3'b001);
        for (int j = 1; j <= 50; j++)
            tick_check("p3_oneshot", (j == 5) ? 3'b001 : 3'b000, (j < 5) ? 3'b001 : 3'b000);
        cfg_write(2'd0, 32'd5, 1'b1);
        check_status("p3_rearm_edge", 3'b000, 3'b001);
        for (int j = 1; j <= 6; j++)
            tick_check("p3_rearm", (j == 5) ? 3'b001 : 3'b000, (j < 5) ? 3'b001 : 3'b000);

        // Write collides with a due strobe
        cfg_write(2'd0, 32'd4, 1'b0);
        check_status("p4_wr_edge", 3'b000, 3'b001);
        for (int j = 1; j <= 7; j++)
            tick_check("p4_pre", (j == 4) ? 3'b001 : 3'b000, 3'b001);
        cfg_write(2'd0, 32'd4, 1'b0);
        check_status("p4_wr_collide", 3'b000, 3'b001);
        for (int j = 1; j <= 4; j++)
            tick_check("p4_restart", (j == 4) ? 3'b001 : 3'b000, 3'b001);

        // Enable drop collides with a due strobe
        for (int j = 1; j <= 3; j++)
            tick_check("p4_run", 3'b000, 3'b001);
        en = 3'b000;
        step();
        check_status("p4_en_collide", 3'b000, 3'b000);
        en = 3'b001;
        step();
        check_status("p4_reen", 3'b000, 3'b001);
        for (int j = 1; j <= 4; j++)
            tick_check("p4_reen_cad", (j == 4) ? 3'b001 : 3'b000, 3'b001);

        // P=0 and P=1 strobe every cycle; the write edge itself is suppressed
        cfg_write(2'd0, 32'd0, 1'b0);
        check_status("p5_p0_edge", 3'b000, 3'b001);
        for (int j = 1; j <= 5; j++)
            tick_check("p5_p0", 3'b001, 3'b001);
        cfg_write(2'd0, 32'd1, 1'b0);
        check_status("p5_wr_prio", 3'b000, 3'b001);
        for (int j = 1; j <= 5; j++)
            tick_check("p5_p1", 3'b001, 3'b001);
        en = 3'b000;
        step();
        check_status("p5_disable", 3'b000, 3'b000);

        // Out-of-range write: error pulse, no channel affected
        en = 3'b001;
        cfg_write(2'd0, 32'd4, 1'b0);
        check_status("p6_wr_edge", 3'b000, 3'b001);
        tick_check("p6_j1", 3'b000, 3'b001);
        cfg_write(2'd3, 32'd7, 1'b1);
        check_status("p6_j2", 3'b000, 3'b001);
        check("p6_err_pulse", {7'b0, cfg_bus.cfg_err_o}, 8'd1);
        tick_check("p6_j3", 3'b000, 3'b001);
        check("p6_err_clear", {7'b0, cfg_bus.cfg_err_o}, 8'd0);
        for (int j = 4; j <= 8; j++)
            tick_check("p6_cadence", (j % 4 == 0) ? 3'b001 : 3'b000, 3'b001);
        en = 3'b110;
        step();
        check_status("p6_swap_en", 3'b000, 3'b110);
        for (int j = 1; j <= 12; j++)
            tick_check("p6_untouched", {(j == 10), (j % 3 == 0), 1'b0}, 3'b110);

        // Asynchronous reset between edges while ch1's strobe is high
        #2;
        rst = 1'b1;
        #1;
        check_status("p7_async", 3'b000, 3'b000);
        check("p7_ready_low", {7'b0, cfg_bus.cfg_ready_o}, 8'd0);
        step();
        check_status("p7_held", 3'b000, 3'b000);
        rst = 1'b0;
        step();
        check_status("p7_rel_edge1", 3'b000, 3'b110);
        check("p7_ready_edge1", {7'b0, cfg_bus.cfg_ready_o}, 8'd0);
        tick_check("p7_default", 3'b000, 3'b110);
        check("p7_ready_edge2", {7'b0, cfg_bus.cfg_ready_o}, 8'd1);
        for (int j = 2; j <= 11; j++)
            tick_check("p7_default", (j == 10) ? 3'b110 : 3'b000, 3'b110);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
